// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, FSM states and keypad matrix mapping for keypad_entry.
package keypad_pkg;
  localparam int NUM_DIGITS = 8;
  typedef enum logic [3:0] {
    KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
    KEY_ENTER, KEY_BACK, KEY_CLEAR, KEY_STAR, KEY_HASH, KEY_D
  } key_t;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  function automatic key_t key_at(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: key_at = KEY_1;
      4'h1: key_at = KEY_2;
      4'h2: key_at = KEY_3;
      4'h3: key_at = KEY_ENTER;
      4'h4: key_at = KEY_4;
      4'h5: key_at = KEY_5;
      4'h6: key_at = KEY_6;
      4'h7: key_at = KEY_BACK;
      4'h8: key_at = KEY_7;
      4'h9: key_at = KEY_8;
      4'ha: key_at = KEY_9;
      4'hb: key_at = KEY_CLEAR;
      4'hc: key_at = KEY_STAR;
      4'hd: key_at = KEY_0;
      4'he: key_at = KEY_HASH;
      default: key_at = KEY_D;
    endcase
  endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix pins plus entry/conversion results; master is the keypad_entry side.
interface keypad_entry_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [31:0] digits;
  logic [31:0] value;
  logic valid;
  logic busy;
  logic neg;
  modport master(input rows, output cols, digits, value, valid, busy, neg);
  modport slave(output rows, input cols, digits, value, valid, busy, neg);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: one-cold column scan, per-frame key classification and press/release debounce.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output key_t       key,
  output logic       key_strobe
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [DW-1:0] div;
  logic [1:0] col;
  logic [3:0] rs0, rs1;
  logic [1:0] fr_cnt;
  key_t fr_key, prev_key, cur_key, frame_key;
  logic [CW-1:0] press_cnt, rel_cnt, pnext;
  logic prev_ok, locked;
  logic sample, last, single, none, match;
  logic [3:0] hit;
  logic [2:0] pc, tot;
  logic [1:0] hit_row;
  assign cols = ~(4'b0001 << col);
  assign key = frame_key;
  // rows pass a 2-flop synchronizer; sampling on the last cycle of a column hides its latency
  always_comb begin
    sample = div == DW'(SCAN_DIV - 1);
    last = sample && col == 2'd3;
    hit = ~rs1;
    pc = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    hit_row = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    cur_key = key_at(hit_row, col);
    tot = 3'(fr_cnt) + pc;
    frame_key = fr_cnt != 2'd0 ? fr_key : cur_key;
    single = tot == 3'd1;
    none = tot == 3'd0;
    match = prev_ok && prev_key == frame_key;
    pnext = match ? press_cnt + 1'b1 : CW'(1);
    key_strobe = last && single && !locked && pnext == CW'(DEBOUNCE_SCANS);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      col <= 2'd0;
      rs0 <= 4'hf;
      rs1 <= 4'hf;
      fr_cnt <= 2'd0;
      fr_key <= KEY_0;
      prev_key <= KEY_0;
      prev_ok <= 1'b0;
      locked <= 1'b0;
      press_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      rs0 <= rows;
      rs1 <= rs0;
      div <= sample ? '0 : div + 1'b1;
      if (sample) begin
        col <= col + 2'd1;
        fr_cnt <= last ? 2'd0 : tot > 3'd1 ? 2'd2 : tot[1:0];
        fr_key <= frame_key;
      end
      if (last) begin
        press_cnt <= single && !locked && !key_strobe ? pnext : '0;
        prev_ok <= single && !locked && !key_strobe;
        prev_key <= frame_key;
        if (key_strobe) locked <= 1'b1;
        else if (locked && none && rel_cnt == CW'(DEBOUNCE_SCANS - 1)) locked <= 1'b0;
        rel_cnt <= locked && none && rel_cnt != CW'(DEBOUNCE_SCANS - 1) ? rel_cnt + 1'b1 : '0;
      end
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad to 8-digit BCD entry buffer with sequential BCD-to-binary conversion on ENTER (sign option: KEYPAD_ENTRY_SIGN_EN).
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic rst_n,
  keypad_entry_if.master bus
);
  key_t key;
  logic key_strobe, take, neg;
  state_t state, nstate;
  logic [31:0] digits, value, acc, acc_next;
  logic [2:0] idx;
  logic [3:0] count;
  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .rows(bus.rows),
    .cols(bus.cols),
    .key(key),
    .key_strobe(key_strobe)
  );
  always_comb begin
    take = state == IDLE && key_strobe;
    acc_next = (acc << 3) + (acc << 1) + 32'(digits[{idx, 2'b00} +: 4]);
    nstate = take && key == KEY_ENTER ? CONV
           : state == CONV && idx == 3'd0 ? DONE
           : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  end
  // value is loaded with the final digit so it is visible together with valid in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      value <= '0;
      acc <= '0;
      idx <= 3'd0;
      count <= 4'd0;
    end else if (take) begin
      if (key < KEY_ENTER && count < 4'(NUM_DIGITS)) begin
        digits <= {digits[27:0], 4'(key)};
        count <= count + 4'd1;
      end
      if (key == KEY_BACK) begin
        digits <= digits >> 4;
        if (count != 4'd0) count <= count - 4'd1;
      end
      if (key == KEY_CLEAR) begin
        digits <= '0;
        count <= 4'd0;
      end
      if (key == KEY_ENTER) begin
        acc <= '0;
        idx <= 3'd7;
      end
    end else if (state == CONV) begin
      acc <= acc_next;
      idx <= idx - 3'd1;
      if (idx == 3'd0) value <= neg ? -acc_next : acc_next;
    end else if (state == DONE) begin
      digits <= '0;
      count <= 4'd0;
    end
  end
`ifdef KEYPAD_ENTRY_SIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg <= 1'b0;
    else if (take && key == KEY_STAR) neg <= ~neg;
    else if ((take && key == KEY_CLEAR) || state == DONE) neg <= 1'b0;
  end
`else
  assign neg = 1'b0;
`endif
  assign bus.digits = digits;
  assign bus.value = value;
  assign bus.valid = state == DONE;
  assign bus.busy = state == CONV;
  assign bus.neg = neg;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed keypad scenarios against keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2.
module tb_keypad_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] pressed = 16'h0;
  int errors = 0, checks = 0;
  int nbusy, nvalid, cyc, first_busy, valid_cyc;
  logic [31:0] vcap;
  logic busy_at_valid, neg_in_busy;
  always #5 clk = ~clk;
  keypad_entry_if bus();
  always_comb for (int r = 0; r < 4; r++) bus.rows[r] = ~|(pressed[r*4 +: 4] & ~bus.cols);
  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [15:0] kp(input int i);
    kp = 16'd1 << i;
  endfunction
  task automatic clear_mon();
    nbusy = 0; nvalid = 0; cyc = 0; first_busy = -1; valid_cyc = -1;
    vcap = 32'hdeadbeef; busy_at_valid = 1'b0; neg_in_busy = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) begin
        if (nbusy == 0) begin first_busy = cyc; neg_in_busy = bus.neg; end
        nbusy++;
      end
      if (bus.valid) begin nvalid++; vcap = bus.value; valid_cyc = cyc; busy_at_valid = bus.busy; end
    end
  endtask
  task automatic press(input logic [15:0] m, input int frames);
    pressed = m;
    run(frames * 16);
    pressed = 16'h0;
    run(48);
  endtask
  task automatic chk_digits(input string name, input logic [31:0] want);
    checks++;
    if (bus.digits !== want) begin errors++; $display("FAIL %s: digits=%h want %h", name, bus.digits, want); end
  endtask
  task automatic chk_conv(input string name, input logic [31:0] want);
    checks++;
    if (nvalid !== 1 || vcap !== want) begin
      errors++; $display("FAIL %s: valid pulses=%0d value=%h want 1 pulse value=%h", name, nvalid, vcap, want);
    end
    checks++;
    if (bus.digits !== 32'h0) begin errors++; $display("FAIL %s_digits_clr: digits=%h want 0", name, bus.digits); end
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if (bus.cols !== 4'b1110 || bus.digits !== 32'h0 || bus.value !== 32'h0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.neg !== 1'b0) begin
      errors++;
      $display("FAIL reset: cols=%b digits=%h value=%h valid=%b busy=%b neg=%b want 1110/0/0/0/0/0", bus.cols, bus.digits, bus.value, bus.valid, bus.busy, bus.neg);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.cols !== 4'b1101) begin errors++; $display("FAIL scan_step: cols=%b want 1101", bus.cols); end
  endtask
  task automatic test_basic();
    clear_mon();
    press(kp(0), 3); chk_digits("d1", 32'h1);
    press(kp(1), 3); chk_digits("d12", 32'h12);
    press(kp(2), 3); chk_digits("d123", 32'h123);
    clear_mon();
    press(kp(3), 3);
    chk_conv("conv123", 32'd123);
    checks++;
    if (nbusy !== 8) begin errors++; $display("FAIL busy_len: busy cycles=%0d want 8", nbusy); end
    checks++;
    if (valid_cyc - first_busy !== 8 || busy_at_valid !== 1'b0) begin
      errors++; $display("FAIL valid_timing: valid offset=%0d busy=%b want 8 and 0", valid_cyc - first_busy, busy_at_valid);
    end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 9; i++) press(kp(10), 3);
    chk_digits("nine_9", 32'h99999999);
    clear_mon();
    press(kp(3), 3);
    chk_conv("conv_max", 32'h05F5E0FF);
  endtask
  task automatic test_debounce();
    press(kp(0), 50); chk_digits("hold50", 32'h1);
    pressed = kp(1); run(12); pressed = 16'h0; run(48);
    chk_digits("glitch", 32'h1);
    press(kp(0) | kp(1), 4); chk_digits("two_keys", 32'h1);
    press(kp(14), 3); press(kp(15), 3); chk_digits("hash_d", 32'h1);
`ifndef KEYPAD_ENTRY_SIGN_EN
    press(kp(12), 3);
    chk_digits("star_ign", 32'h1);
    checks++;
    if (bus.neg !== 1'b0) begin errors++; $display("FAIL star_neg: neg=%b want 0", bus.neg); end
`endif
    press(kp(11), 3); chk_digits("clear1", 32'h0);
  endtask
  task automatic test_backspace();
    press(kp(4), 3); press(kp(5), 3); press(kp(7), 3);
    chk_digits("back", 32'h4);
    press(kp(6), 3); chk_digits("d46", 32'h46);
    clear_mon();
    press(kp(3), 3);
    chk_conv("conv46", 32'd46);
  endtask
  task automatic test_reset_conv();
    int n;
    press(kp(0), 3);
    pressed = kp(3);
    n = 0;
    while (!bus.busy && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bus.busy) begin errors++; $display("FAIL conv_start: busy=%b want 1 within 200 cycles", bus.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    pressed = 16'h0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.value !== 32'h0 || bus.digits !== 32'h0 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL rst_conv: busy=%b value=%h digits=%h valid=%b want 0/0/0/0", bus.busy, bus.value, bus.digits, bus.valid);
    end
    clear_mon();
    run(5);
    rst_n = 1'b1;
    run(64);
    checks++;
    if (nvalid !== 0 || bus.value !== 32'h0) begin errors++; $display("FAIL rst_novalid: pulses=%0d value=%h want 0/0", nvalid, bus.value); end
  endtask
  task automatic test_clear();
    press(kp(8), 3); chk_digits("d7", 32'h7);
    press(kp(11), 3); chk_digits("clear7", 32'h0);
    clear_mon();
    press(kp(3), 3);
    chk_conv("conv0", 32'h0);
  endtask
`ifdef KEYPAD_ENTRY_SIGN_EN
  task automatic test_sign();
    press(kp(12), 3);
    checks++;
    if (bus.neg !== 1'b1 || bus.digits !== 32'h0) begin errors++; $display("FAIL star_neg: neg=%b digits=%h want 1/0", bus.neg, bus.digits); end
    press(kp(5), 3); chk_digits("d5", 32'h5);
    clear_mon();
    press(kp(3), 3);
    chk_conv("conv_neg5", 32'hFFFFFFFB);
    checks++;
    if (neg_in_busy !== 1'b1 || bus.neg !== 1'b0) begin errors++; $display("FAIL neg_life: during=%b after=%b want 1/0", neg_in_busy, bus.neg); end
  endtask
`endif
  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_overflow();
    test_debounce();
    test_backspace();
    test_reset_conv();
    test_clear();
`ifdef KEYPAD_ENTRY_SIGN_EN
    test_sign();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
